// File: rtl/divider.sv
// Sequential restoring divider: one quotient bit every two cycles.
// The dividend is loaded into Q with Load. The divisor is captured from SW when
// Run is accepted. Quotient and remainder are shown on four active-low 7-segment
// digits. The quotient stays in Q after each operation, so divisions can be chained.
//
// Handshake: Run is a level request. It starts one operation on a rising
// request seen in IDLE, that is, after Run has been observed low at least once.
// Busy stays high while the operation runs. Done then holds high until Run
// drops, and the FSM returns to IDLE on that edge.
// Qval/Rval are meaningful only while Busy is low.
//
// The HEX digit mapping assumes WIDTH == 8.
module divider #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] SW,
  input  logic             Load,
  input  logic             Run,
  output logic [WIDTH-1:0] Qval,
  output logic [WIDTH-1:0] Rval,
  output logic             Busy,
  output logic             Done,
  output logic             Div_Zero,
  output logic             Overflow,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, PREP, SHIFT, SUB, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] q, r, d;
  // The bit shifted out of R. It keeps the partial remainder exact when the
  // divisor magnitude has its top bit set.
  logic             rc;
  logic             sq, sr;
  logic [CW-1:0]    cnt;
  // Set once Run has been seen low. A held Run never restarts the FSM.
  logic             run_armed;
  logic             fits;
  logic [WIDTH-1:0] diff;

  // Magnitude of a two's-complement value. The most negative value maps to itself,
  // which still reads correctly as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // Standard active-low hex glyphs, 0-F.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Trial subtraction of the divisor from the (WIDTH+1)-bit partial remainder.
  assign fits = ({rc, r} >= {1'b0, d});
  assign diff = r - d;

  // Control FSM and datapath registers, with Busy/Done registered alongside the state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      q         <= '0;
      r         <= '0;
      d         <= '0;
      rc        <= 1'b0;
      sq        <= 1'b0;
      sr        <= 1'b0;
      cnt       <= '0;
      run_armed <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Div_Zero  <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      if (!Run) run_armed <= 1'b1;
      case (state)
        IDLE: begin
          if (Run && run_armed) begin
            d         <= SW;
            Div_Zero  <= 1'b0;
            Overflow  <= 1'b0;
            sq        <= 1'b0;
            sr        <= 1'b0;
            run_armed <= 1'b0;
            Busy      <= 1'b1;
            state     <= PREP;
          end else if (Load) begin
            q  <= SW;
            r  <= '0;
            rc <= 1'b0;
          end
        end
        PREP: begin
          rc <= 1'b0;
          if (d == '0) begin
            Div_Zero <= 1'b1;
            q        <= ALL_ONES;
            r        <= q;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            state    <= DONE;
          end else begin
            // Clear R so that a chained operation starts from a clean partial remainder.
            r <= '0;
            if (SIGNED) begin
              sq <= q[WIDTH-1] ^ d[WIDTH-1];
              sr <= q[WIDTH-1];
              q  <= mag(q);
              d  <= mag(d);
            end
            Overflow <= SIGNED && (q == MOST_NEG) && (d == ALL_ONES);
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {rc, r, q} <= {r, q, 1'b0};
          state      <= SUB;
        end
        SUB: begin
          if (fits) begin
            r    <= diff;
            rc   <= 1'b0;
            q[0] <= 1'b1;
          end
          if (cnt == LAST) begin
            state <= FIX;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= SHIFT;
          end
        end
        FIX: begin
          if (SIGNED && sq) q <= -q;
          if (SIGNED && sr) r <= -r;
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (!Run) begin
            Done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Qval      = q;
  assign Rval      = r;
  assign dbg_state = state;
  assign HEX0      = hex7(q[3:0]);
  assign HEX1      = hex7(q[7:4]);
  assign HEX2      = hex7(r[3:0]);
  assign HEX3      = hex7(r[7:4]);

endmodule

// File: tb/tb_divider.sv
// Bench for divider: one signed and one unsigned instance are driven from shared inputs.
// The bench runs a vector table, hand-written corner sequences, and random
// operations checked against an arithmetic model.
module tb_divider;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] SW;
  logic       Load;
  logic       Run;

  logic [7:0] s_q, s_r, u_q, u_r;
  logic       s_busy, s_done, s_dz, s_ov, u_busy, u_done, u_dz, u_ov;
  logic [6:0] s_h0, s_h1, s_h2, s_h3, u_h0, u_h1, u_h2, u_h3;
  logic [2:0] s_dbg, u_dbg;

  int total  = 0;
  int passed = 0;

  localparam logic [6:0] ZERO_GLYPH = 7'b1000000;

  divider #(.WIDTH(8), .SIGNED(1'b1)) u_sgn (
    .Clk(Clk), .Reset(Reset), .SW(SW), .Load(Load), .Run(Run),
    .Qval(s_q), .Rval(s_r), .Busy(s_busy), .Done(s_done),
    .Div_Zero(s_dz), .Overflow(s_ov),
    .HEX0(s_h0), .HEX1(s_h1), .HEX2(s_h2), .HEX3(s_h3), .dbg_state(s_dbg)
  );

  divider #(.WIDTH(8), .SIGNED(1'b0)) u_uns (
    .Clk(Clk), .Reset(Reset), .SW(SW), .Load(Load), .Run(Run),
    .Qval(u_q), .Rval(u_r), .Busy(u_busy), .Done(u_done),
    .Div_Zero(u_dz), .Overflow(u_ov),
    .HEX0(u_h0), .HEX1(u_h1), .HEX2(u_h2), .HEX3(u_h3), .dbg_state(u_dbg)
  );

  // Clock and watchdog.
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q_s;
    logic [7:0] r_s;
    logic [7:0] q_u;
    logic [7:0] r_u;
    logic       dz;
    logic       ov;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    SW   = v;
    Load = 1'b1;
    step();
    Load = 1'b0;
    step();
  endtask

  // Start a division and wait (bounded) for Done on both instances. Then drop Run.
  task automatic do_div(input logic [7:0] b, output int lat, output bit busy_ok);
    int  k;
    bit  got;
    SW      = b;
    Run     = 1'b1;
    step();
    k       = 0;
    got     = 1'b0;
    busy_ok = 1'b1;
    lat     = -1;
    while (!got && k < 60) begin
      if (s_done && u_done) begin
        got = 1'b1;
        lat = k;
        if (s_busy || u_busy) busy_ok = 1'b0;
      end else begin
        if (!s_busy || !u_busy) busy_ok = 1'b0;
        step();
        k++;
      end
    end
    Run = 1'b0;
    step();
  endtask

  // Reference: truncating division. The remainder takes the dividend's sign.
  // Divide-by-zero and the signed overflow case have fixed results.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    int sa, sb, qq, rr;
    if (b == 8'h00) return {8'hFF, a};
    if (sgn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -128 && sb == -1) return {8'h80, 8'h00};
      qq = sa / sb;
      rr = sa % sb;
    end else begin
      sa = int'(a);
      sb = int'(b);
      qq = sa / sb;
      rr = sa % sb;
    end
    return {qq[7:0], rr[7:0]};
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g [16];
    g = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return g[n];
  endfunction

  initial begin
    int          lat;
    bit          bok;
    logic [15:0] ms, mu;
    logic [7:0]  a, b;
    int          first_done;
    bit          late_busy, dropped;

    vecs[0] = '{8'h64, 8'h07, 8'h0E, 8'h02, 8'h0E, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 8'h7C, 8'h01, 1'b0, 1'b0};
    vecs[2] = '{8'h07, 8'hFE, 8'hFD, 8'h01, 8'h00, 8'h07, 1'b0, 1'b0};
    vecs[3] = '{8'h2A, 8'h00, 8'hFF, 8'h2A, 8'hFF, 8'h2A, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 8'h80, 8'h00, 8'hFF, 8'h01, 8'h7F, 1'b0, 1'b0};
    vecs[6] = '{8'hC8, 8'hF0, 8'h03, 8'hF8, 8'h00, 8'hC8, 1'b0, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 8'h7F, 8'h00, 8'h7F, 8'h00, 1'b0, 1'b0};
    vecs[8] = '{8'hFE, 8'h03, 8'h00, 8'hFE, 8'h54, 8'h02, 1'b0, 1'b0};

    // Reset.
    Reset = 1'b0;
    SW    = 8'h00;
    Load  = 1'b0;
    Run   = 1'b0;
    repeat (3) step();
    check("reset_q", s_q, 8'h00);
    check("reset_r", s_r, 8'h00);
    check("reset_busy_done", {s_busy, s_done, u_busy, u_done}, 4'b0000);
    check("reset_flags", {s_dz, s_ov}, 2'b00);
    check("reset_hex", {s_h0, s_h1, s_h2, s_h3}, {4{ZERO_GLYPH}});
    Reset = 1'b1;
    repeat (2) step();

    // Vector table.
    foreach (vecs[i]) begin
      do_load(vecs[i].a);
      do_div(vecs[i].b, lat, bok);
      check($sformatf("vec%0d_q_signed", i), s_q, vecs[i].q_s);
      check($sformatf("vec%0d_r_signed", i), s_r, vecs[i].r_s);
      check($sformatf("vec%0d_q_unsigned", i), u_q, vecs[i].q_u);
      check($sformatf("vec%0d_r_unsigned", i), u_r, vecs[i].r_u);
      check($sformatf("vec%0d_flags", i), {s_dz, s_ov, u_dz, u_ov},
            {vecs[i].dz, vecs[i].ov, vecs[i].dz, 1'b0});
      if (vecs[i].dz) check($sformatf("vec%0d_lat_le2", i), (lat >= 1 && lat <= 2), 1);
      else            check($sformatf("vec%0d_latency", i), lat, 18);
      check($sformatf("vec%0d_busy_window", i), bok, 1'b1);
      check($sformatf("vec%0d_done_cleared", i), {s_done, u_done}, 2'b00);
      if (i == 0) begin
        check("vec0_hex_unsigned", {u_h0, u_h1, u_h2, u_h3},
              {7'b0000110, ZERO_GLYPH, 7'b0100100, ZERO_GLYPH});
      end
    end

    // Long Run hold: exactly one operation, Done held until Run drops.
    do_load(8'h64);
    SW  = 8'h07;
    Run = 1'b1;
    step();
    first_done = -1;
    late_busy  = 1'b0;
    dropped    = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (s_done && first_done < 0) first_done = k;
      if (first_done >= 0 && !s_done) dropped = 1'b1;
      if (k >= 18 && s_busy) late_busy = 1'b1;
      step();
    end
    check("longrun_first_done", first_done, 18);
    check("longrun_no_restart", late_busy, 1'b0);
    check("longrun_done_held", dropped, 1'b0);
    check("longrun_q", s_q, 8'h0E);
    Run = 1'b0;
    step();
    check("longrun_release_idle", {s_done, s_busy}, 2'b00);

    // Chaining: divide the previous quotient 0x0E by 2.
    do_div(8'h02, lat, bok);
    check("chain_q_signed", {s_q, s_r}, {8'h07, 8'h00});
    check("chain_q_unsigned", {u_q, u_r}, {8'h07, 8'h00});

    // Load while busy must be ignored.
    do_load(8'h64);
    SW  = 8'h07;
    Run = 1'b1;
    repeat (3) step();
    SW   = 8'h55;
    Load = 1'b1;
    step();
    Load = 1'b0;
    lat  = 0;
    while (!s_done && lat < 60) begin
      step();
      lat++;
    end
    check("busy_load_done_seen", s_done, 1'b1);
    check("busy_load_ignored", {s_q, s_r}, {8'h0E, 8'h02});
    Run = 1'b0;
    step();

    // Asynchronous reset in the middle of an operation.
    do_load(8'h64);
    SW  = 8'h07;
    Run = 1'b1;
    repeat (5) step();
    Reset = 1'b0;
    #1;
    check("midreset_qr", {s_q, s_r}, 16'h0000);
    check("midreset_busy_done", {s_busy, s_done}, 2'b00);
    check("midreset_hex", {s_h0, s_h1, s_h2, s_h3}, {4{ZERO_GLYPH}});
    step();
    Reset = 1'b1;
    repeat (3) step();
    check("held_run_no_start", {s_busy, s_done, u_busy, u_done}, 4'b0000);
    Run = 1'b0;
    step();
    do_load(8'h64);
    do_div(8'h07, lat, bok);
    check("restart_result", {s_q, s_r}, {8'h0E, 8'h02});
    check("restart_latency", lat, 18);

    // Random operations against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if (n == 5) begin a = 8'h80; b = 8'hFF; end
      ms = model(a, b, 1'b1);
      mu = model(a, b, 1'b0);
      do_load(a);
      do_div(b, lat, bok);
      check($sformatf("rand%0d_signed_%0h_%0h", n, a, b), {s_q, s_r}, ms);
      check($sformatf("rand%0d_unsigned_%0h_%0h", n, a, b), {u_q, u_r}, mu);
      check($sformatf("rand%0d_flags", n), {s_dz, s_ov, u_dz, u_ov},
            {b == 8'h00, (a == 8'h80 && b == 8'hFF), b == 8'h00, 1'b0});
      check($sformatf("rand%0d_hex", n), {s_h0, s_h1, s_h2, s_h3},
            {glyph(ms[11:8]), glyph(ms[15:12]), glyph(ms[3:0]), glyph(ms[7:4])});
      if (b != 8'h00) check($sformatf("rand%0d_latency", n), lat, 18);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
